// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared state type and default dimensions for the Sobel flow path
package sobel_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } flow_state_e;

  localparam int DEF_IMG_W     = 640;
  localparam int DEF_IMG_H     = 480;
  localparam int DEF_SLACK     = 8;
  localparam int DEF_DRAIN_CYC = 16;

endpackage

// File: rtl/pix_pos_cnt.sv
// rtl/pix_pos_cnt.sv - column/row raster counter with last-pixel flag
module pix_pos_cnt
  import sobel_pkg::*;
#(
  parameter int W = DEF_IMG_W,
  parameter int H = DEF_IMG_H
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 adv,
  output logic [$clog2(W)-1:0] col,
  output logic [$clog2(H)-1:0] row,
  output logic                 last
);

  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);
  localparam logic [CW-1:0] COL_MAX = CW'(W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);

  assign last = (col == COL_MAX) && (row == ROW_MAX);

  // Advance one pixel in raster order; the final pixel wraps both axes at once.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sobel_flow_ctrl.sv
// rtl/sobel_flow_ctrl.sv - frame-level pop/throttle/drain controller for the Sobel path
module sobel_flow_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W      = DEF_IMG_W,
  parameter int IMG_H      = DEF_IMG_H,
  parameter int FIFO_DEPTH = 2048,
  parameter int CNT_WD     = 11,
  parameter int SLACK      = DEF_SLACK,
  parameter int DRAIN_CYC  = DEF_DRAIN_CYC
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic                     cam_empty_i,
  input  logic [CNT_WD-1:0]        sobel_cnt_i,
  input  logic                     sobel_vld_i,
  output logic                     rd_cam_fifo_o,
  output logic [$clog2(IMG_W)-1:0] col_o,
  output logic [$clog2(IMG_H)-1:0] row_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [19:0]              out_cnt_o,
  output logic                     ovf_err_o
);

  localparam int DW = $clog2(DRAIN_CYC + 1);
  // One extra bit so a depth equal to 2**CNT_WD is still representable.
  localparam logic [CNT_WD:0] POP_LIMIT  = (CNT_WD + 1)'(FIFO_DEPTH - SLACK);
  localparam logic [CNT_WD:0] FULL_LEVEL = (CNT_WD + 1)'(FIFO_DEPTH - 1);
  localparam logic [DW-1:0]   DRAIN_LAST = DW'(DRAIN_CYC - 1);

  flow_state_e     state;
  flow_state_e     next_state;
  logic [DW-1:0]   drain_cnt;
  logic [CNT_WD:0] occ;
  logic            room;
  logic            full;
  logic            pop;
  logic            last_pix;
  logic            start_ok;

  assign occ      = {1'b0, sobel_cnt_i};
  assign room     = occ < POP_LIMIT;
  assign full     = occ >= FULL_LEVEL;
  assign start_ok = (state == IDLE) && start_i && !abort_i;

  assign rd_cam_fifo_o = pop;

  pix_pos_cnt #(
    .W(IMG_W),
    .H(IMG_H)
  ) u_pos (
    .clk (clk_i),
    .rst (rst_i),
    .clr (start_ok),
    .adv (pop),
    .col (col_o),
    .row (row_o),
    .last(last_pix)
  );

  // Next state and the zero-latency pop strobe; abort forces IDLE with no pop.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    if (abort_i) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: if (start_i) next_state = RUN;
        RUN: begin
          pop = !rst_i && !cam_empty_i && room;
          if (pop && last_pix) next_state = DRAIN;
        end
        DRAIN: if (!sobel_vld_i && (drain_cnt == DRAIN_LAST)) next_state = DONE;
        DONE: next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // State register with busy/done registered from the upcoming state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      state  <= next_state;
      busy_o <= (next_state == RUN) || (next_state == DRAIN);
      done_o <= (next_state == DONE);
    end
  end

  // Count idle datapath cycles while draining; any valid restarts the wait.
  always_ff @(posedge clk_i) begin
    if (rst_i || start_ok) begin
      drain_cnt <= '0;
    end else if (state == DRAIN) begin
      drain_cnt <= sobel_vld_i ? '0 : drain_cnt + 1'b1;
    end
  end

  // Saturating output counter and sticky overflow flag, live in every state.
  always_ff @(posedge clk_i) begin
    if (rst_i || start_ok) begin
      out_cnt_o <= '0;
      ovf_err_o <= 1'b0;
    end else if (sobel_vld_i) begin
      if (out_cnt_o != '1) out_cnt_o <= out_cnt_o + 1'b1;
      if (full) ovf_err_o <= 1'b1;
    end
  end

endmodule

// File: doc/sobel_flow_ctrl.md
# sobel_flow_ctrl

Frame-level flow controller for the Sobel edge-detection path. It sits between the camera FIFO and the Sobel datapath (RGB565→gray→3-line buffer→convolution→Sobel output FIFO). It issues the pop/enable strobe that advances the datapath one pixel, throttles on Sobel FIFO occupancy to prevent overflow, and tracks pixel column/row. It declares a frame complete once the convolution pipeline has drained.

## Interface
Parameters:
- IMG_W, 640, pixels per line
- IMG_H, 480, lines per frame
- FIFO_DEPTH, 2048, Sobel output FIFO depth (entries)
- CNT_WD, 11, width of the FIFO occupancy count
- SLACK, 8, headroom reserved for pixels in flight in the datapath pipeline
- DRAIN_CYC, 16, idle cycles on the datapath valid that mark the pipeline as drained

Ports:
- clk_i  in  1  system clock (the datapath write-side clock)
- rst_i  in  1  reset; synchronous and active-high
- start_i  in  1  one-cycle request to process one frame
- abort_i  in  1  synchronous abort; returns to IDLE, no done
- cam_empty_i  in  1  camera FIFO empty
- sobel_cnt_i  in  CNT_WD  Sobel FIFO write-side occupancy
- sobel_vld_i  in  1  datapath output valid (the Sobel FIFO write enable)
- rd_cam_fifo_o  out  1  pop camera FIFO / advance datapath
- col_o  out  $clog2(IMG_W)  column of the next pixel to pop
- row_o  out  $clog2(IMG_H)  row of the next pixel to pop
- busy_o  out  1  frame in progress (RUN or DRAIN)
- done_o  out  1  one-cycle pulse at frame completion
- out_cnt_o  out  20  Sobel outputs written this frame
- ovf_err_o  out  1  sticky: output written while the Sobel FIFO was full

## Operation
- States are IDLE, RUN, DRAIN and DONE.
- **IDLE**
  - start_i → RUN.
  - On entry to RUN: col, row, out_cnt, drain counter and ovf_err are all cleared.
- **RUN**
  - rd_cam_fifo_o = !cam_empty_i && (sobel_cnt_i < FIFO_DEPTH−SLACK).
  - Each pop increments col. At col = IMG_W−1, col wraps to 0 and row increments.
  - A pop at (IMG_W−1, IMG_H−1) moves the FSM to DRAIN. col/row then return to 0.
- **DRAIN**
  - No pops.
  - The drain counter resets to 0 on every sobel_vld_i and increments otherwise.
  - When the counter reaches DRAIN_CYC−1 with no sobel_vld_i → DONE.
- **DONE**
  - done_o = 1 for exactly one cycle, then → IDLE.
- **All states**
  - Every sobel_vld_i increments out_cnt_o. The count saturates at all-ones.
  - sobel_vld_i while sobel_cnt_i ≥ FIFO_DEPTH−1 sets ovf_err_o. It clears only on reset or a new start.
- **Precedence**
  - rst_i has priority over abort_i, which has priority over start_i.
  - abort_i in any state → IDLE. rd_cam_fifo_o is 0 that same cycle. done_o is not pulsed.
  - start_i outside IDLE is ignored.
- **Boundary cases**
  - Camera FIFO empty: RUN holds col/row with no pop, indefinitely.
  - Occupancy at threshold: the pop is suppressed. Exactly FIFO_DEPTH−SLACK−1 still pops.
  - Wrap: both col and row wrap on the final pixel pop in the same cycle.

## Timing
- Reset values: state IDLE, rd_cam_fifo_o 0, col_o 0, row_o 0, busy_o 0, done_o 0, out_cnt_o 0, ovf_err_o 0.
- rd_cam_fifo_o is combinational from the registered state and the current cam_empty_i / sobel_cnt_i. This gives zero-latency response and guarantees the camera FIFO is never popped while empty.
- All other outputs are registered.
- col_o/row_o update the cycle after a pop.
- busy_o is 1 from the cycle after start_i through the last DRAIN cycle.
- done_o is asserted DRAIN_CYC+1 cycles after the last sobel_vld_i, provided no further valid arrives.
- Minimum frame time with no stalls: IMG_W·IMG_H pops + drain + 1.

## Structure
- Shared package `sobel_pkg` holds:
  - the state enum `flow_state_e` {IDLE, RUN, DRAIN, DONE};
  - default image dimensions;
  - SLACK / DRAIN_CYC constants.
- Sub-module `pix_pos_cnt` is the col/row wrap counter with a last-pixel flag. It is reusable by the SDRAM address generator.
- Estimated at roughly 150–250 lines of RTL.

## Test plan
Small-frame configuration unless noted: IMG_W=4, IMG_H=3, FIFO_DEPTH=32, SLACK=4, DRAIN_CYC=4.

1. **Basic frame**
   - Stimulus: start_i, cam_empty_i=0, sobel_cnt_i=0, sobel_vld_i driven 3 cycles after each pop.
   - Required: exactly 12 pops; col/row sequence (0,0)…(3,2); out_cnt_o=12; done_o single pulse 5 cycles after the last valid; busy_o falls with it.
2. **Backpressure**
   - Stimulus: sobel_cnt_i=28 (the threshold).
   - Required: no pops. Dropping to 27 → pop the same cycle.
3. **Empty camera FIFO**
   - Stimulus: cam_empty_i toggles 1/0 every cycle.
   - Required: pops only on cam_empty_i=0 cycles; 12 pops total; col/row never skip.
4. **Abort**
   - Stimulus: abort_i after pop 5.
   - Required: next cycle state IDLE, busy_o=0, no done_o. A following start_i restarts at (0,0) with out_cnt_o=0.
5. **Overflow flag**
   - Stimulus: sobel_vld_i with sobel_cnt_i=31.
   - Required: ovf_err_o=1 and stays 1 through DONE; cleared by the next start_i.
6. **Reset and start while busy**
   - Stimulus: rst_i mid-RUN; also start_i during DRAIN.
   - Required: rst_i → all outputs at reset values next cycle. start_i during DRAIN is ignored: frame completes with one done_o and out_cnt_o is not cleared.
